// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration helpers for the parameterised synchronous FIFO.
package sync_fifo_pkg;

  // Per-cycle operation, encoded as {rd_ok, wr_ok}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  // Bits needed to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic bit thresh_ok(input int addr_w, input int afull, input int aempty);
    int depth;
    depth = 1 << addr_w;
    return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a FIFO producer/consumer (master) and the FIFO (slave).
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  localparam int CNT_W = cnt_width(1 << ADDR_W);

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, din, rd_en,
    input  dout, dout_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, din, rd_en,
    output dout, dout_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_sdp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO using all 2**ADDR_W entries, standard or FWFT read port,
// registered level flags and sticky overflow/underflow.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 4,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AEMPTY_THRESH);

  if (!thresh_ok(ADDR_W, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
    $error("sync_fifo_param: AFULL_THRESH/AEMPTY_THRESH out of range");
  end

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              full_q, empty_q, afull_q, aempty_q, ovf_q, udf_q;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] rdata;
  fifo_op_e          op;

  // Acceptance is judged on the flags registered at the start of the cycle.
  assign wr_ok = bus.wr_en & ~full_q;
  assign rd_ok = bus.rd_en & ~empty_q;
  assign op    = fifo_op_e'({rd_ok, wr_ok});

  always_comb begin
    cnt_nxt = cnt_q;
    unique case (op)
      OP_WR:   cnt_nxt = cnt_q + CNT_W'(1);
      OP_RD:   cnt_nxt = cnt_q - CNT_W'(1);
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      cnt_q    <= cnt_nxt;
      full_q   <= (cnt_nxt == DEPTH_C);
      empty_q  <= (cnt_nxt == '0);
      afull_q  <= (cnt_nxt >= AF_C);
      aempty_q <= (cnt_nxt <= AE_C);
    end
  end

  // Error flags survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (!bus.flush) begin
      if (bus.wr_en && full_q)  ovf_q <= 1'b1;
      if (bus.rd_en && empty_q) udf_q <= 1'b1;
    end
  end

  fifo_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_ok & ~bus.flush & ~reset),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  if (FWFT) begin : g_fwft
    assign bus.dout       = rdata;
    assign bus.dout_valid = ~empty_q;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;
    logic              dv_q;

    always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else begin
        dv_q <= rd_ok;
        if (rd_ok) dout_q <= rdata;
      end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a standard-mode and an FWFT-mode FIFO in lockstep against a queue model.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(16), .ADDR_W(4)) bs ();
  sync_fifo_param_if #(.DATA_W(16), .ADDR_W(4)) bf ();

  sync_fifo_param #(.DATA_W(16), .ADDR_W(4), .FWFT(1'b0), .AFULL_THRESH(12), .AEMPTY_THRESH(2))
    u_std (.clk(clk), .reset(reset), .bus(bs));
  sync_fifo_param #(.DATA_W(16), .ADDR_W(4), .FWFT(1'b1), .AFULL_THRESH(12), .AEMPTY_THRESH(2))
    u_fwft (.clk(clk), .reset(reset), .bus(bf));

  // Reference model: contents as a queue, plus sticky errors and standard-port output.
  logic [15:0] q[$];
  logic        m_ovf, m_udf, m_sdv;
  logic [15:0] m_sdout;

  task automatic step(input logic w, input logic [15:0] d, input logic r,
                      input logic f, input logic rs);
    int n;
    reset = rs;
    bs.wr_en = w; bs.din = d; bs.rd_en = r; bs.flush = f;
    bf.wr_en = w; bf.din = d; bf.rd_en = r; bf.flush = f;
    @(posedge clk);
    n = q.size();
    if (rs) begin
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_sdout = '0; m_sdv = 1'b0;
    end else if (f) begin
      q.delete(); m_sdout = '0; m_sdv = 1'b0;
    end else begin
      m_sdv = 1'b0;
      if (r && n > 0) begin m_sdout = q.pop_front(); m_sdv = 1'b1; end
      if (w && n < 16) q.push_back(d);
      if (w && n == 16) m_ovf = 1'b1;
      if (r && n == 0)  m_udf = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 1);
    checks++; if (bs.count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bs.count); end
    checks++; if (bs.empty !== 1'b1 || bf.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b/%b exp 1", bs.empty, bf.empty); end
    checks++; if (bs.full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", bs.full); end
    checks++; if (bs.almost_empty !== 1'b1 || bs.almost_full !== 1'b0) begin errors++; $display("FAIL rst_aflags got ae=%b af=%b exp ae=1 af=0", bs.almost_empty, bs.almost_full); end
    checks++; if (bs.overflow !== 1'b0 || bs.underflow !== 1'b0) begin errors++; $display("FAIL rst_err got ovf=%b udf=%b exp 0 0", bs.overflow, bs.underflow); end
    checks++; if (bs.dout !== 16'h0 || bs.dout_valid !== 1'b0 || bf.dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout got %h v=%b fv=%b exp 0 0 0", bs.dout, bs.dout_valid, bf.dout_valid); end
  endtask

  task automatic test_fill_drain();
    step(0, 16'h0, 0, 0, 1);
    for (int i = 1; i <= 16; i++) begin
      step(1, 16'(i), 0, 0, 0);
      checks++; if (bs.almost_full !== (i >= 12) || bf.almost_full !== (i >= 12)) begin errors++; $display("FAIL fill_af cnt=%0d got %b/%b exp %b", i, bs.almost_full, bf.almost_full, i >= 12); end
      checks++; if (bs.almost_empty !== (i <= 2)) begin errors++; $display("FAIL fill_ae cnt=%0d got %b exp %b", i, bs.almost_empty, i <= 2); end
    end
    checks++; if (bs.full !== 1'b1 || bs.count !== 5'd16 || bf.count !== 5'd16) begin errors++; $display("FAIL fill_full got full=%b cnt=%0d/%0d exp 1 16", bs.full, bs.count, bf.count); end
    for (int i = 1; i <= 16; i++) begin
      checks++; if (bf.dout !== 16'(i) || bf.dout_valid !== 1'b1) begin errors++; $display("FAIL drain_fwft got %h v=%b exp %h", bf.dout, bf.dout_valid, 16'(i)); end
      step(0, 16'h0, 1, 0, 0);
      checks++; if (bs.dout !== 16'(i) || bs.dout_valid !== 1'b1) begin errors++; $display("FAIL drain_std got %h v=%b exp %h", bs.dout, bs.dout_valid, 16'(i)); end
    end
    checks++; if (bs.empty !== 1'b1 || bf.empty !== 1'b1 || bf.dout_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b/%b fv=%b exp 1 1 0", bs.empty, bf.empty, bf.dout_valid); end
    checks++; if (bs.overflow !== 1'b0 || bs.underflow !== 1'b0 || bf.overflow !== 1'b0) begin errors++; $display("FAIL fill_noerr got ovf=%b udf=%b exp 0 0", bs.overflow, bs.underflow); end
  endtask

  task automatic test_overflow();
    step(0, 16'h0, 0, 0, 1);
    for (int i = 1; i <= 16; i++) step(1, 16'(i), 0, 0, 0);
    step(1, 16'hAAAA, 0, 0, 0);
    checks++; if (bs.overflow !== 1'b1 || bf.overflow !== 1'b1 || bs.count !== 5'd16) begin errors++; $display("FAIL ovf_set got %b/%b cnt=%0d exp 1 1 16", bs.overflow, bf.overflow, bs.count); end
    for (int i = 1; i <= 16; i++) begin
      step(0, 16'h0, 1, 0, 0);
      checks++; if (bs.dout !== 16'(i)) begin errors++; $display("FAIL ovf_data got %h exp %h", bs.dout, 16'(i)); end
    end
    checks++; if (bs.empty !== 1'b1 || bs.overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold got empty=%b ovf=%b exp 1 1", bs.empty, bs.overflow); end
  endtask

  task automatic test_simultaneous();
    step(0, 16'h0, 0, 0, 1);
    for (int i = 1; i <= 16; i++) step(1, 16'(i), 0, 0, 0);
    step(1, 16'h5555, 1, 0, 0);
    checks++; if (bs.count !== 5'd15 || bs.overflow !== 1'b1 || bs.dout !== 16'h1) begin errors++; $display("FAIL rw_full got cnt=%0d ovf=%b d=%h exp 15 1 0001", bs.count, bs.overflow, bs.dout); end
    for (int i = 2; i <= 16; i++) step(0, 16'h0, 1, 0, 0);
    checks++; if (bs.dout !== 16'd16 || bs.empty !== 1'b1) begin errors++; $display("FAIL rw_nodrop got %h empty=%b exp 0010 1", bs.dout, bs.empty); end
    step(1, 16'h7777, 1, 0, 0);
    checks++; if (bs.count !== 5'd1 || bs.underflow !== 1'b1 || bs.dout_valid !== 1'b0) begin errors++; $display("FAIL rw_empty got cnt=%0d udf=%b v=%b exp 1 1 0", bs.count, bs.underflow, bs.dout_valid); end
    checks++; if (bf.dout !== 16'h7777 || bf.underflow !== 1'b1) begin errors++; $display("FAIL rw_empty_fwft got %h udf=%b exp 7777 1", bf.dout, bf.underflow); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_d;
    step(0, 16'h0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 16'(100 + i), 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      exp_d = (k < 5) ? 16'(100 + k) : 16'(200 + k - 5);
      checks++; if (bf.dout !== exp_d) begin errors++; $display("FAIL wrap_fwft k=%0d got %h exp %h", k, bf.dout, exp_d); end
      step(1, 16'(200 + k), 1, 0, 0);
      checks++; if (bs.dout !== exp_d || bs.count !== 5'd5) begin errors++; $display("FAIL wrap_std k=%0d got %h cnt=%0d exp %h 5", k, bs.dout, bs.count, exp_d); end
    end
  endtask

  task automatic test_fwft_latency();
    step(0, 16'h0, 0, 0, 1);
    step(1, 16'h1234, 0, 0, 0);
    checks++; if (bf.dout !== 16'h1234 || bf.dout_valid !== 1'b1) begin errors++; $display("FAIL fwft_lat got %h v=%b exp 1234 1", bf.dout, bf.dout_valid); end
    step(0, 16'h0, 1, 0, 0);
    checks++; if (bf.empty !== 1'b1 || bf.dout_valid !== 1'b0) begin errors++; $display("FAIL fwft_pop got empty=%b v=%b exp 1 0", bf.empty, bf.dout_valid); end
  endtask

  task automatic test_flush_reset();
    step(0, 16'h0, 0, 0, 1);
    for (int i = 1; i <= 16; i++) step(1, 16'(i), 0, 0, 0);
    step(1, 16'hAAAA, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 16'h0, 1, 0, 0);
    checks++; if (bs.count !== 5'd7 || bs.overflow !== 1'b1) begin errors++; $display("FAIL pre_flush got cnt=%0d ovf=%b exp 7 1", bs.count, bs.overflow); end
    step(1, 16'hCCCC, 1, 1, 0);
    checks++; if (bs.count !== 5'd0 || bs.empty !== 1'b1 || bs.overflow !== 1'b1 || bf.overflow !== 1'b1) begin errors++; $display("FAIL flush got cnt=%0d empty=%b ovf=%b exp 0 1 1", bs.count, bs.empty, bs.overflow); end
    checks++; if (bs.dout !== 16'h0 || bs.dout_valid !== 1'b0 || bf.dout_valid !== 1'b0) begin errors++; $display("FAIL flush_dout got %h v=%b fv=%b exp 0 0 0", bs.dout, bs.dout_valid, bf.dout_valid); end
    step(0, 16'h0, 0, 0, 1);
    checks++; if (bs.overflow !== 1'b0 || bs.almost_empty !== 1'b1 || bs.count !== 5'd0) begin errors++; $display("FAIL post_rst got ovf=%b ae=%b cnt=%0d exp 0 1 0", bs.overflow, bs.almost_empty, bs.count); end
    step(1, 16'hBEEF, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    checks++; if (bs.dout !== 16'hBEEF || bs.dout_valid !== 1'b1) begin errors++; $display("FAIL post_rst_data got %h v=%b exp beef 1", bs.dout, bs.dout_valid); end
  endtask

  task automatic test_random();
    logic w, r, f;
    logic [4:0] mc;
    step(0, 16'h0, 0, 0, 1);
    for (int k = 0; k < 600; k++) begin
      // Bias toward writes then reads so both full and empty are visited.
      w = ($urandom_range(99) < (((k / 60) % 2 == 0) ? 75 : 30));
      r = ($urandom_range(99) < (((k / 60) % 2 == 0) ? 30 : 75));
      f = ($urandom_range(99) < 2);
      if (!f && q.size() > 0) begin
        checks++; if (bf.dout !== q[0] || bf.dout_valid !== 1'b1) begin errors++; $display("FAIL rnd_fwft k=%0d got %h v=%b exp %h 1", k, bf.dout, bf.dout_valid, q[0]); end
      end
      step(w, 16'($urandom), r, f, 0);
      mc = 5'(q.size());
      checks++; if (bs.count !== mc || bf.count !== mc) begin errors++; $display("FAIL rnd_count k=%0d got %0d/%0d exp %0d", k, bs.count, bf.count, mc); end
      checks++; if (bs.full !== (mc == 16) || bs.empty !== (mc == 0) || bf.dout_valid !== (mc != 0)) begin errors++; $display("FAIL rnd_fe k=%0d got f=%b e=%b fv=%b cnt=%0d", k, bs.full, bs.empty, bf.dout_valid, mc); end
      checks++; if (bs.almost_full !== (mc >= 12) || bs.almost_empty !== (mc <= 2)) begin errors++; $display("FAIL rnd_aflags k=%0d got af=%b ae=%b cnt=%0d", k, bs.almost_full, bs.almost_empty, mc); end
      checks++; if (bs.overflow !== m_ovf || bs.underflow !== m_udf || bf.overflow !== m_ovf || bf.underflow !== m_udf) begin errors++; $display("FAIL rnd_err k=%0d got %b%b exp %b%b", k, bs.overflow, bs.underflow, m_ovf, m_udf); end
      checks++; if (bs.dout_valid !== m_sdv || bs.dout !== m_sdout) begin errors++; $display("FAIL rnd_std k=%0d got %h v=%b exp %h %b", k, bs.dout, bs.dout_valid, m_sdout, m_sdv); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bs.wr_en = 1'b0; bs.rd_en = 1'b0; bs.flush = 1'b0; bs.din = '0;
    bf.wr_en = 1'b0; bf.rd_en = 1'b0; bf.flush = 1'b0; bf.din = '0;
    m_ovf = 1'b0; m_udf = 1'b0; m_sdv = 1'b0; m_sdout = '0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_fwft_latency();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
